nlm_blend_out: RTL

//   Downstream stage of the NLM denoiser. Blends the denoised and original pixel

---
 rtl/nlm_blend_out_if.sv | 14 +
 rtl/nlm_blend_out.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/nlm_blend_out_if.sv
// Valid/ready output stream of the NLM blend stage: one pixel word plus frame markers.
interface nlm_blend_out_if #(
  parameter int unsigned DATA_WIDTH = 12
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  sof;
  logic                  eol;
  logic                  eof;

  modport master (output valid, data, sof, eol, eof, input ready);
  modport slave  (input valid, data, sof, eol, eof, output ready);
endinterface

// File: rtl/nlm_blend_out.sv
// NLM output stage: blends denoised/original pixels with a per-frame strength, re-derives
// SOF/EOL/EOF from a frame/line counter and buffers words in a first-word-fall-through FIFO.
module nlm_blend_out #(
  parameter int unsigned DATA_WIDTH   = 12,
  parameter int unsigned IMAGE_WIDTH  = 1920,
  parameter int unsigned IMAGE_HEIGHT = 1080,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid_i,
  input  logic [DATA_WIDTH-1:0]         pix_original_i,
  input  logic [DATA_WIDTH-1:0]         pix_denoise_i,
  input  logic                          frame_sync_i,
  input  logic                          line_sync_i,
  input  logic [4:0]                    alpha_i,
  input  logic                          bypass_i,
  input  logic                          err_clr_i,
  nlm_blend_out_if.master               m,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  output logic                          geom_err_o
);
  localparam int unsigned ColW  = $clog2(IMAGE_WIDTH + 1);
  localparam int unsigned RowW  = $clog2(IMAGE_HEIGHT + 1);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW  = AddrW + 1;
  localparam int unsigned ProdW = DATA_WIDTH + 5;
  localparam int unsigned WordW = DATA_WIDTH + 3;
  localparam logic [ColW-1:0] LastCol = ColW'(IMAGE_WIDTH - 1);
  localparam logic [RowW-1:0] LastRow = RowW'(IMAGE_HEIGHT - 1);
  localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);

  typedef enum logic {StIdle, StActive} state_e;

  state_e          state_q, state_d;
  logic [ColW-1:0] col_q, col_d, col_cur;
  logic [RowW-1:0] row_q, row_d, row_cur;
  logic [4:0]      alpha_q, alpha_d, alpha_sat, a_eff;
  logic            bypass_q, bypass_d;
  logic            accept, sof, eol, eof, geom_evt;

  logic             s1_valid_q, s1_sof_q, s1_eol_q, s1_eof_q;
  logic [ProdW-1:0] s1_prod_dn_q, s1_prod_org_q, prod_dn_d, prod_org_d;
  logic             s2_valid_q;
  logic [WordW-1:0] s2_word_q, s2_word_d;

  logic [WordW-1:0] mem_q [FIFO_DEPTH];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  count_q, count_d;
  logic             rd_en, wr_en, ovf_evt;
  logic             overflow_q, overflow_d, geom_err_q, geom_err_d;
  logic [WordW-1:0] head;

  // Strength is taken from the live inputs on the SOF pixel so that pixel already uses it.
  always_comb begin
    alpha_sat  = (alpha_i > 5'd16) ? 5'd16 : alpha_i;
    alpha_d    = (valid_i && frame_sync_i) ? alpha_sat : alpha_q;
    bypass_d   = (valid_i && frame_sync_i) ? bypass_i : bypass_q;
    a_eff      = bypass_d ? 5'd0 : alpha_d;
    prod_dn_d  = ProdW'(pix_denoise_i) * ProdW'(a_eff);
    prod_org_d = ProdW'(pix_original_i) * ProdW'(5'd16 - a_eff);
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    col_cur  = col_q;
    row_cur  = row_q;
    accept   = 1'b0;
    sof      = 1'b0;
    eol      = 1'b0;
    eof      = 1'b0;
    geom_evt = 1'b0;
    if (valid_i) begin
      case (state_q)
        StIdle: begin
          if (frame_sync_i) begin
            accept  = 1'b1;
            sof     = 1'b1;
            col_cur = '0;
            row_cur = '0;
          end else begin
            geom_evt = 1'b1;
          end
        end
        StActive: begin
          accept = 1'b1;
          if (frame_sync_i) begin
            sof      = 1'b1;
            col_cur  = '0;
            row_cur  = '0;
            geom_evt = 1'b1;
          end else if (line_sync_i && col_q != '0) begin
            col_cur  = '0;
            geom_evt = 1'b1;
          end else if (!line_sync_i && col_q == '0) begin
            geom_evt = 1'b1;
          end
        end
        default: ;
      endcase
      if (accept) begin
        eol     = (col_cur == LastCol);
        eof     = eol && (row_cur == LastRow);
        state_d = eof ? StIdle : StActive;
        if (eol) begin
          col_d = '0;
          row_d = eof ? '0 : row_cur + RowW'(1);
        end else begin
          col_d = col_cur + ColW'(1);
          row_d = row_cur;
        end
      end
    end
  end

  // Rounded blend cannot exceed max(dn, org), so the shifted sum fits DATA_WIDTH.
  always_comb begin
    s2_word_d = {s1_sof_q, s1_eol_q, s1_eof_q,
                 DATA_WIDTH'((s1_prod_dn_q + s1_prod_org_q + ProdW'(8)) >> 4)};
  end

  always_comb begin
    rd_en      = (count_q != '0) && m.ready;
    wr_en      = s2_valid_q && ((count_q != LvlFull) || rd_en);
    ovf_evt    = s2_valid_q && (count_q == LvlFull) && !rd_en;
    wr_ptr_d   = wr_en ? wr_ptr_q + AddrW'(1) : wr_ptr_q;
    rd_ptr_d   = rd_en ? rd_ptr_q + AddrW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (wr_en && !rd_en) begin
      count_d = count_q + LvlW'(1);
    end else if (!wr_en && rd_en) begin
      count_d = count_q - LvlW'(1);
    end
    overflow_d = ovf_evt || (overflow_q && !err_clr_i);
    geom_err_d = geom_evt || (geom_err_q && !err_clr_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      col_q         <= '0;
      row_q         <= '0;
      alpha_q       <= '0;
      bypass_q      <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_sof_q      <= 1'b0;
      s1_eol_q      <= 1'b0;
      s1_eof_q      <= 1'b0;
      s1_prod_dn_q  <= '0;
      s1_prod_org_q <= '0;
      s2_valid_q    <= 1'b0;
      s2_word_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      geom_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      alpha_q       <= alpha_d;
      bypass_q      <= bypass_d;
      s1_valid_q    <= accept;
      s1_sof_q      <= sof;
      s1_eol_q      <= eol;
      s1_eof_q      <= eof;
      s1_prod_dn_q  <= prod_dn_d;
      s1_prod_org_q <= prod_org_d;
      s2_valid_q    <= s1_valid_q;
      s2_word_q     <= s2_word_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      geom_err_q    <= geom_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= s2_word_q;
    end
  end

  // Head word is gated so every stream output reads 0 while the FIFO is empty.
  assign head         = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign m.valid      = (count_q != '0);
  assign m.data       = head[DATA_WIDTH-1:0];
  assign m.sof        = head[WordW-1];
  assign m.eol        = head[WordW-2];
  assign m.eof        = head[WordW-3];
  assign fifo_level_o = count_q;
  assign overflow_o   = overflow_q;
  assign geom_err_o   = geom_err_q;
endmodule
